// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit:
// opcodes, functs, ALU codes, state encodings and mux select codes.
package mips_multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_LUI = 4'd4;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    localparam logic [2:0] SRCB_B     = 3'd0;
    localparam logic [2:0] SRCB_4     = 3'd1;
    localparam logic [2:0] SRCB_SEXT  = 3'd2;
    localparam logic [2:0] SRCB_SEXT2 = 3'd3;
    localparam logic [2:0] SRCB_ZEXT  = 3'd4;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BRANCH   = 4'd8,
        S_IMM_EX   = 4'd9,
        S_IMM_WB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        CLS_ADD   = 2'd0,
        CLS_SUB   = 2'd1,
        CLS_RTYPE = 2'd2,
        CLS_IMM   = 2'd3
    } aluop_cls_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control <-> datapath bundle: instruction fields and zero flag in,
// ALU code, mux selects, write enables and debug state out.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] aluctrl;
    logic       alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero,
        output aluctrl, alusrca, alusrcb, pcsrc, pcen, iord,
        output memwrite, irwrite, regdst, memtoreg, regwrite,
        output illegal, state
    );

    modport slave (
        output opcode, funct, zero,
        input  aluctrl, alusrca, alusrcb, pcsrc, pcen, iord,
        input  memwrite, irwrite, regdst, memtoreg, regwrite,
        input  illegal, state
    );
endinterface

// File: rtl/mips_aluop_decode.sv
// ALU op decoder: (class, opcode, funct) -> aluctrl.
// bad_funct flags an unsupported R-type funct regardless of class.
module mips_aluop_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  aluop_cls_t cls,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] aluctrl,
    output logic       bad_funct
);
    logic [3:0] f_code;
    logic       f_ok;

    always_comb begin
        f_code = ALU_ADD;
        f_ok   = 1'b1;
        case (funct)
            F_ADD:   f_code = ALU_ADD;
            F_SUB:   f_code = ALU_SUB;
            F_AND:   f_code = ALU_AND;
            F_OR:    f_code = ALU_OR;
            F_NOR:   f_code = ALU_NOR;
            F_SLT:   f_code = ALU_SLT;
            default: f_ok   = 1'b0;
        endcase
    end

    assign bad_funct = (opcode == OP_RTYPE) && !f_ok;

    always_comb begin
        aluctrl = ALU_ADD;
        unique case (cls)
            CLS_ADD:   aluctrl = ALU_ADD;
            CLS_SUB:   aluctrl = ALU_SUB;
            CLS_RTYPE: aluctrl = f_code;
            CLS_IMM: begin
                case (opcode)
                    OP_SLTI: aluctrl = ALU_SLT;
                    OP_ANDI: aluctrl = ALU_AND;
                    OP_ORI:  aluctrl = ALU_OR;
                    OP_LUI:  aluctrl = ALU_LUI;
                    default: aluctrl = ALU_ADD;
                endcase
            end
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/wb
// and drives all datapath selects and enables through the bus.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master bus
);
    state_t     state, next;
    aluop_cls_t cls;
    logic [3:0] dec_alu;
    logic       bad_funct;
    logic       use_dec;

    mips_aluop_decode u_dec (
        .cls       (cls),
        .opcode    (bus.opcode),
        .funct     (bus.funct),
        .aluctrl   (dec_alu),
        .bad_funct (bad_funct)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= state_t'(RESET_STATE);
        else       state <= next;
    end

    assign bus.state = state;

    always_comb begin
        next         = S_FETCH;
        cls          = CLS_ADD;
        use_dec      = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = SRCB_B;
        bus.pcsrc    = PC_ALU;
        bus.pcen     = 1'b0;
        bus.iord     = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regwrite = 1'b0;
        bus.illegal  = 1'b0;
        case (state)
            S_FETCH: begin
                bus.irwrite = 1'b1;
                bus.alusrcb = SRCB_4;
                bus.pcen    = 1'b1;
                use_dec     = 1'b1;
                next        = S_DECODE;
            end
            S_DECODE: begin
                bus.alusrcb = SRCB_SEXT2;
                use_dec     = 1'b1;
                case (bus.opcode)
                    OP_LW, OP_SW:   next = S_MEMADR;
                    OP_BEQ, OP_BNE: next = S_BRANCH;
                    OP_J:           next = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI,
                    OP_ORI, OP_LUI: next = S_IMM_EX;
                    OP_RTYPE: begin
                        bus.illegal = bad_funct;
                        next = bad_funct ? S_FETCH : S_RTYPE_EX;
                    end
                    default: bus.illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_SEXT;
                use_dec     = 1'b1;
                next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                next     = S_MEMWB;
            end
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_RTYPE_EX: begin
                bus.alusrca = 1'b1;
                cls         = CLS_RTYPE;
                use_dec     = 1'b1;
                next        = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                bus.pcsrc   = PC_ALUOUT;
                cls         = CLS_SUB;
                use_dec     = 1'b1;
                bus.pcen    = (bus.opcode == OP_BNE) ? ~bus.zero
                                                     : bus.zero;
            end
            S_IMM_EX: begin
                bus.alusrca = 1'b1;
                cls         = CLS_IMM;
                use_dec     = 1'b1;
                bus.alusrcb = (bus.opcode == OP_ADDI ||
                               bus.opcode == OP_SLTI) ? SRCB_SEXT
                                                      : SRCB_ZEXT;
                next        = S_IMM_WB;
            end
            S_IMM_WB: bus.regwrite = 1'b1;
            S_JUMP: begin
                bus.pcsrc = PC_JUMP;
                bus.pcen  = 1'b1;
            end
            default: next = S_FETCH;
        endcase
        bus.aluctrl = use_dec ? dec_alu : ALU_AND;
        // Reset must never let a write slip through mid-instruction.
        if (reset) begin
            bus.pcen     = 1'b0;
            bus.memwrite = 1'b0;
            bus.irwrite  = 1'b0;
            bus.regwrite = 1'b0;
            bus.illegal  = 1'b0;
            bus.aluctrl  = ALU_ADD;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl.
// Each task drives one instruction class and checks states/outputs.
module tb_mips_multicycle_ctrl;
    import mips_multicycle_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus();

    mips_multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.opcode = 6'h3F;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;
        cyc();
        cyc();
        checks++;
        if (bus.state !== 4'd0) begin
            errors++;
            $display("FAIL rst_state got=%0d want=0", bus.state);
        end
        checks++;
        if ({bus.pcen, bus.memwrite, bus.irwrite,
             bus.regwrite, bus.illegal} !== 5'b0) begin
            errors++;
            $display("FAIL rst_en got=%b want=00000",
                     {bus.pcen, bus.memwrite, bus.irwrite,
                      bus.regwrite, bus.illegal});
        end
        checks++;
        if (bus.aluctrl !== 4'd2) begin
            errors++;
            $display("FAIL rst_alu got=%0d want=2", bus.aluctrl);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.irwrite, bus.pcen, bus.aluctrl, bus.alusrcb}
            !== {1'b1, 1'b1, 4'd2, 3'd1}) begin
            errors++;
            $display("FAIL fetch got=%b want=%b",
                     {bus.irwrite, bus.pcen, bus.aluctrl, bus.alusrcb},
                     {1'b1, 1'b1, 4'd2, 3'd1});
        end
    endtask

    task automatic test_rtype();
        logic [3:0] exp [5];
        exp = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        bus.opcode = 6'h00;
        bus.funct  = 6'h22;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.state !== exp[i]) begin
                errors++;
                $display("FAIL rtype_st%0d got=%0d want=%0d",
                         i, bus.state, exp[i]);
            end
            if (i == 2) begin
                checks++;
                if ({bus.aluctrl, bus.alusrcb} !== {4'd6, 3'd0}) begin
                    errors++;
                    $display("FAIL rtype_ex got=%0d/%0d want=6/0",
                             bus.aluctrl, bus.alusrcb);
                end
            end
            if (i == 3) begin
                checks++;
                if ({bus.regwrite, bus.regdst} !== 2'b11) begin
                    errors++;
                    $display("FAIL rtype_wb got=%b want=11",
                             {bus.regwrite, bus.regdst});
                end
            end
            if (i < 4) cyc();
        end
    endtask

    task automatic test_lw_sw();
        logic [3:0] lw [6];
        logic [3:0] sw [5];
        lw = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        sw = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        bus.opcode = OP_LW;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.state !== lw[i]) begin
                errors++;
                $display("FAIL lw_st%0d got=%0d want=%0d",
                         i, bus.state, lw[i]);
            end
            if (i == 3) begin
                checks++;
                if (bus.iord !== 1'b1) begin
                    errors++;
                    $display("FAIL lw_iord got=%b want=1", bus.iord);
                end
            end
            if (i == 4) begin
                checks++;
                if ({bus.memtoreg, bus.regwrite, bus.regdst}
                    !== 3'b110) begin
                    errors++;
                    $display("FAIL lw_wb got=%b want=110",
                             {bus.memtoreg, bus.regwrite, bus.regdst});
                end
            end
            if (i < 5) cyc();
        end
        bus.opcode = OP_SW;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.state !== sw[i]) begin
                errors++;
                $display("FAIL sw_st%0d got=%0d want=%0d",
                         i, bus.state, sw[i]);
            end
            if (i == 3) begin
                checks++;
                if ({bus.memwrite, bus.iord, bus.regwrite}
                    !== 3'b110) begin
                    errors++;
                    $display("FAIL sw_wr got=%b want=110",
                             {bus.memwrite, bus.iord, bus.regwrite});
                end
            end
            if (i < 4) cyc();
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [2];
        logic       pe  [2];
        ops = '{OP_BEQ, OP_BNE};
        pe  = '{1'b1, 1'b0};
        bus.zero = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.opcode = ops[k];
            cyc();
            cyc();
            checks++;
            if (bus.state !== 4'd8) begin
                errors++;
                $display("FAIL br%0d_st got=%0d want=8", k, bus.state);
            end
            checks++;
            if ({bus.pcen, bus.pcsrc, bus.aluctrl, bus.alusrca}
                !== {pe[k], 2'd1, 4'd6, 1'b1}) begin
                errors++;
                $display("FAIL br%0d_out got=%b want=%b", k,
                         {bus.pcen, bus.pcsrc, bus.aluctrl, bus.alusrca},
                         {pe[k], 2'd1, 4'd6, 1'b1});
            end
            cyc();
            checks++;
            if (bus.state !== 4'd0) begin
                errors++;
                $display("FAIL br%0d_ret got=%0d want=0", k, bus.state);
            end
        end
        bus.zero = 1'b0;
        bus.opcode = OP_BNE;
        cyc();
        cyc();
        checks++;
        if (bus.pcen !== 1'b1) begin
            errors++;
            $display("FAIL bne_taken got=%b want=1", bus.pcen);
        end
        cyc();
    endtask

    task automatic test_imm();
        logic [5:0] ops [2];
        logic [3:0] alu [2];
        ops = '{OP_ORI, OP_LUI};
        alu = '{4'd1, 4'd4};
        for (int k = 0; k < 2; k++) begin
            bus.opcode = ops[k];
            cyc();
            cyc();
            checks++;
            if ({bus.state, bus.alusrcb, bus.aluctrl, bus.alusrca}
                !== {4'd9, 3'd4, alu[k], 1'b1}) begin
                errors++;
                $display("FAIL imm%0d_ex got=%b want=%b", k,
                         {bus.state, bus.alusrcb, bus.aluctrl, bus.alusrca},
                         {4'd9, 3'd4, alu[k], 1'b1});
            end
            cyc();
            checks++;
            if ({bus.state, bus.regwrite, bus.regdst, bus.memtoreg}
                !== {4'd10, 3'b100}) begin
                errors++;
                $display("FAIL imm%0d_wb got=%b want=%b", k,
                         {bus.state, bus.regwrite, bus.regdst, bus.memtoreg},
                         {4'd10, 3'b100});
            end
            cyc();
        end
        bus.opcode = OP_ADDI;
        cyc();
        cyc();
        checks++;
        if ({bus.alusrcb, bus.aluctrl} !== {3'd2, 4'd2}) begin
            errors++;
            $display("FAIL addi_ex got=%0d/%0d want=2/2",
                     bus.alusrcb, bus.aluctrl);
        end
        cyc();
        cyc();
    endtask

    task automatic test_jump();
        bus.opcode = OP_J;
        cyc();
        cyc();
        checks++;
        if ({bus.state, bus.pcsrc, bus.pcen} !== {4'd11, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL jump got=%b want=%b",
                     {bus.state, bus.pcsrc, bus.pcen},
                     {4'd11, 2'd2, 1'b1});
        end
        cyc();
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2];
        logic [5:0] fns [2];
        ops = '{6'h3F, 6'h00};
        fns = '{6'h20, 6'h01};
        for (int k = 0; k < 2; k++) begin
            bus.opcode = ops[k];
            bus.funct  = fns[k];
            cyc();
            checks++;
            if ({bus.state, bus.illegal, bus.pcen, bus.regwrite,
                 bus.memwrite, bus.irwrite} !== {4'd1, 5'b10000}) begin
                errors++;
                $display("FAIL ill%0d_dec got=%b want=%b", k,
                         {bus.state, bus.illegal, bus.pcen, bus.regwrite,
                          bus.memwrite, bus.irwrite}, {4'd1, 5'b10000});
            end
            cyc();
            checks++;
            if ({bus.state, bus.illegal} !== {4'd0, 1'b0}) begin
                errors++;
                $display("FAIL ill%0d_ret got=%b want=%b", k,
                         {bus.state, bus.illegal}, {4'd0, 1'b0});
            end
        end
    endtask

    task automatic test_reset_midway();
        bus.opcode = OP_LW;
        cyc();
        cyc();
        cyc();
        checks++;
        if (bus.state !== 4'd3) begin
            errors++;
            $display("FAIL mid_memrd got=%0d want=3", bus.state);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.regwrite, bus.memwrite, bus.pcen, bus.irwrite}
            !== 4'b0) begin
            errors++;
            $display("FAIL mid_en got=%b want=0000",
                     {bus.regwrite, bus.memwrite, bus.pcen, bus.irwrite});
        end
        bus.opcode = 6'h3F;
        cyc();
        checks++;
        if ({bus.state, bus.regwrite} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_rst got=%b want=%b",
                     {bus.state, bus.regwrite}, {4'd0, 1'b0});
        end
        reset = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({bus.state, bus.regwrite} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_after got=%b want=%b",
                     {bus.state, bus.regwrite}, {4'd0, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_sw();
        test_branch();
        test_imm();
        test_jump();
        test_illegal();
        test_reset_midway();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
